// File: rtl/aemb_pkg.sv
// rtl/aemb_pkg.sv - shared types and field positions for the shifter scheduler
//
// Purpose: shift mode codes, scheduler FSM state encodings, bsf_alt field
//   layout and the helper that builds bsf_alt from a latched mode.
// Ports: none (package).

package aemb_pkg;

  localparam int ALT_W      = 11;
  localparam int ALT_MOD_HI = 10;
  localparam int ALT_MOD_LO = 9;
  localparam int SHAMT_W    = 5;

  typedef enum logic [1:0] {
    MOD_SRL = 2'd0,
    MOD_SRA = 2'd1,
    MOD_SLL = 2'd2,
    MOD_ILL = 2'd3
  } bsf_mod_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

  // The shifter has no defined behaviour for the illegal code, so it is
  // steered to the SRL encoding instead; the result is discarded anyway.
  function automatic logic [ALT_W-1:0] alt_for_mod(input logic [1:0] mode);
    logic [ALT_W-1:0] alt;
    alt = '0;
    if (mode != MOD_ILL) alt[ALT_MOD_HI:ALT_MOD_LO] = mode;
    return alt;
  endfunction

endpackage

// File: rtl/aemb_bsft_sched_if.sv
// rtl/aemb_bsft_sched_if.sv - request, shifter and response bus of the scheduler
//
// Purpose: bundles the two request channels, the shared shifter operand/result
//   lines and the valid/ready response channel.
// Modports:
//   master - scheduler side: takes req_*, bsf_res, rsp_rdy; drives req_ack,
//            bsf_opa/opb/alt and rsp_stb/tag/res/err.
//   slave  - requesters, external shifter and response consumer.

interface aemb_bsft_sched_if
  import aemb_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREQ = 2
);

  logic [NREQ-1:0]         req_stb;
  logic [NREQ-1:0][DW-1:0] req_opa;
  logic [NREQ-1:0][DW-1:0] req_opb;
  logic [NREQ-1:0][1:0]    req_mod;
  logic [NREQ-1:0]         req_ack;

  logic [DW-1:0]           bsf_opa;
  logic [DW-1:0]           bsf_opb;
  logic [ALT_W-1:0]        bsf_alt;
  logic [DW-1:0]           bsf_res;

  logic                    rsp_stb;
  logic                    rsp_tag;
  logic [DW-1:0]           rsp_res;
  logic                    rsp_err;
  logic                    rsp_rdy;

  modport master (
    input  req_stb, req_opa, req_opb, req_mod, bsf_res, rsp_rdy,
    output req_ack, bsf_opa, bsf_opb, bsf_alt, rsp_stb, rsp_tag, rsp_res, rsp_err
  );

  modport slave (
    output req_stb, req_opa, req_opb, req_mod, bsf_res, rsp_rdy,
    input  req_ack, bsf_opa, bsf_opb, bsf_alt, rsp_stb, rsp_tag, rsp_res, rsp_err
  );

endinterface

// File: rtl/aemb_rr_arb2.sv
// rtl/aemb_rr_arb2.sv - two-way round-robin arbiter
//
// Purpose: picks one of two requesters; on a tie the requester that did not
//   win last time gets the grant. The pointer only moves when the grant is
//   actually taken.
// Ports:
//   clk_i      in   clock
//   rst_i      in   asynchronous active-high reset (pointer -> 1)
//   req_i      in   request vector
//   adv_i      in   grant consumed this cycle; pointer <= winner
//   gnt_o      out  one-hot grant (combinational)
//   gnt_idx_o  out  index of the granted requester

module aemb_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  // Holds the last winner; reset to 1 so requester 0 wins the first tie.
  logic rr_q;
  logic rr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || rr_q)) gnt_o[0] = 1'b1;
    else if (req_i[1])                   gnt_o[1] = 1'b1;
  end

  assign gnt_idx_o = gnt_o[1];

  always_comb begin
    rr_d = rr_q;
    if (adv_i && (|req_i)) rr_d = gnt_idx_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= 1'b1;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/aemb_bsft_sched.sv
// rtl/aemb_bsft_sched.sv - round-robin scheduler for one shared barrel shifter
//
// Purpose: grants one of two requesters, latches its operands, drives the
//   external single-cycle shifter for one cycle, captures the result and
//   returns it with the requester tag on a valid/ready response channel.
// Ports:
//   gclk  in   clock, all state on rising edge
//   grst  in   asynchronous active-high reset
//   gena  in   global enable; low freezes all state and suppresses req_ack
//   bus   -    aemb_bsft_sched_if.master: req_*, bsf_*, rsp_*

module aemb_bsft_sched
  import aemb_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREQ = 2
) (
  input  logic              gclk,
  input  logic              grst,
  input  logic              gena,
  aemb_bsft_sched_if.master bus
);

  sched_state_e          state_q;
  logic [DW-1:0]         opa_q;
  logic [SHAMT_W-1:0]    shamt_q;
  logic [1:0]            mod_q;
  logic                  tag_q;

  logic                  rsp_stb_q;
  logic                  rsp_tag_q;
  logic [DW-1:0]         rsp_res_q;
  logic                  rsp_err_q;

  logic [NREQ-1:0]       gnt;
  logic                  gnt_idx;
  logic                  can_grant;
  logic                  take;

  // Only opb[4:0] is a shift amount; the rest of the word is don't-care.
  logic                  unused_opb_hi;
  assign unused_opb_hi = ^{bus.req_opb[0][DW-1:SHAMT_W], bus.req_opb[1][DW-1:SHAMT_W]};

  // A new request may be taken from IDLE, or from RESP in the same cycle the
  // held response is consumed, which gives one op per two cycles.
  assign can_grant = !grst && gena &&
                     ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_rdy));
  assign take      = can_grant && (|bus.req_stb);

  aemb_rr_arb2 u_arb (
    .clk_i     (gclk),
    .rst_i     (grst),
    .req_i     (bus.req_stb),
    .adv_i     (take),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign bus.req_ack = can_grant ? gnt : '0;

  // Shifter inputs come straight from the latched request, so they are stable
  // for the whole EXEC cycle.
  assign bus.bsf_opa = opa_q;
  assign bus.bsf_opb = {{(DW-SHAMT_W){1'b0}}, shamt_q};
  assign bus.bsf_alt = alt_for_mod(mod_q);

  assign bus.rsp_stb = rsp_stb_q;
  assign bus.rsp_tag = rsp_tag_q;
  assign bus.rsp_res = rsp_res_q;
  assign bus.rsp_err = rsp_err_q;

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state_q   <= ST_IDLE;
      opa_q     <= '0;
      shamt_q   <= '0;
      mod_q     <= MOD_SRL;
      tag_q     <= 1'b0;
      rsp_stb_q <= 1'b0;
      rsp_tag_q <= 1'b0;
      rsp_res_q <= '0;
      rsp_err_q <= 1'b0;
    end else if (gena) begin
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            opa_q   <= bus.req_opa[gnt_idx];
            shamt_q <= bus.req_opb[gnt_idx][SHAMT_W-1:0];
            mod_q   <= bus.req_mod[gnt_idx];
            tag_q   <= gnt_idx;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_stb_q <= 1'b1;
          rsp_tag_q <= tag_q;
          rsp_err_q <= (mod_q == MOD_ILL);
          rsp_res_q <= (mod_q == MOD_ILL) ? '0 : bus.bsf_res;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_rdy) begin
            rsp_stb_q <= 1'b0;
            if (take) begin
              opa_q   <= bus.req_opa[gnt_idx];
              shamt_q <= bus.req_opb[gnt_idx][SHAMT_W-1:0];
              mod_q   <= bus.req_mod[gnt_idx];
              tag_q   <= gnt_idx;
              state_q <= ST_EXEC;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aemb_bsft_sched.sv
// tb/tb_aemb_bsft_sched.sv - scoreboard bench for the shifter scheduler

module tb_aemb_bsft_sched;
  import aemb_pkg::*;

  logic gclk = 1'b0;
  logic grst;
  logic gena;

  aemb_bsft_sched_if #(.DW(32), .NREQ(2)) bus ();

  aemb_bsft_sched #(.DW(32), .NREQ(2)) dut (
    .gclk (gclk),
    .grst (grst),
    .gena (gena),
    .bus  (bus)
  );

  always #5 gclk = ~gclk;

  // External single-cycle barrel shifter.
  always_comb begin
    case (bus.bsf_alt[10:9])
      2'd0:    bus.bsf_res = bus.bsf_opa >> bus.bsf_opb[4:0];
      2'd1:    bus.bsf_res = 32'($signed(bus.bsf_opa) >>> bus.bsf_opb[4:0]);
      2'd2:    bus.bsf_res = bus.bsf_opa << bus.bsf_opb[4:0];
      default: bus.bsf_res = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct packed {
    logic        tag;
    logic [31:0] res;
    logic        err;
  } rsp_t;

  rsp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   hs_cnt   = 0;
  int   rise_cyc = -1;
  logic stb_prev = 1'b0;

  always @(posedge gclk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void push_exp(input logic tag, input logic [31:0] res, input logic err);
    rsp_t e;
    e.tag = tag;
    e.res = res;
    e.err = err;
    exp_q.push_back(e);
  endfunction

  // Monitor: pops one expectation per response handshake.
  initial begin
    rsp_t e;
    forever begin
      @(negedge gclk);
      if (grst) begin
        stb_prev = 1'b0;
      end else begin
        if (bus.rsp_stb && !stb_prev) rise_cyc = cyc;
        stb_prev = bus.rsp_stb;
        if (bus.rsp_stb && bus.rsp_rdy && gena) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: got tag %0d res %h err %0d, expected no response",
                     bus.rsp_tag, bus.rsp_res, bus.rsp_err);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
            chk("rsp_res", bus.rsp_res, e.res);
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic do_req(input int i, input logic [31:0] opa, input logic [31:0] opb,
                        input logic [1:0] mode, output int ack_cyc);
    bus.req_opa[i] = opa;
    bus.req_opb[i] = opb;
    bus.req_mod[i] = mode;
    bus.req_stb[i] = 1'b1;
    ack_cyc = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge gclk);
      if (bus.req_ack[i]) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (ack_cyc < 0) begin
      n_checks++;
      $display("FAIL ack_timeout: requester %0d got no req_ack within 60 cycles", i);
    end
    @(posedge gclk);
    #1;
    bus.req_stb[i] = 1'b0;
  endtask

  task automatic wait_hs(input int n, input string name);
    for (int k = 0; k < 100 && hs_cnt < n; k++) @(negedge gclk);
    if (hs_cnt < n) begin
      n_checks++;
      $display("FAIL %s: got %0d responses expected %0d", name, hs_cnt, n);
    end
  endtask

  task automatic do_reset();
    grst = 1'b1;
    tick();
    grst = 1'b0;
    tick();
  endtask

  initial begin
    int   a, a0, a1;
    int   a0s [3];
    int   a1s [3];
    logic [31:0] snap_res;
    logic snap_tag, snap_err, stable, quiet;

    grst        = 1'b1;
    gena        = 1'b1;
    bus.req_stb = 2'b01;
    bus.req_opa = '0;
    bus.req_opb = '0;
    bus.req_mod = '0;
    bus.rsp_rdy = 1'b1;

    // Reset state, with a request already present.
    @(posedge gclk);
    @(negedge gclk);
    chk("rst_req_ack", 32'(bus.req_ack), 32'h0);
    chk("rst_rsp_stb", 32'(bus.rsp_stb), 32'h0);
    chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'h0);
    chk("rst_rsp_res", bus.rsp_res, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("rst_bsf_opa", bus.bsf_opa, 32'h0);
    chk("rst_bsf_opb", bus.bsf_opb, 32'h0);
    chk("rst_bsf_alt", 32'(bus.bsf_alt), 32'h0);
    tick();
    bus.req_stb = 2'b00;
    grst = 1'b0;
    tick();

    // 1: single SLL, ack -> rsp_stb latency of two cycles.
    push_exp(1'b0, 32'h0000_0010, 1'b0);
    do_req(0, 32'h0000_0001, 32'd4, MOD_SLL, a0);
    @(negedge gclk);
    chk("t1_bsf_alt", 32'(bus.bsf_alt), 32'h0000_0400);
    chk("t1_bsf_opa", bus.bsf_opa, 32'h0000_0001);
    wait_hs(1, "t1_rsp");
    chk("t1_latency", 32'(rise_cyc - a0), 32'd2);
    tick();

    // Shift amount boundaries: opb=32 is shift 0, upper opb bits ignored.
    push_exp(1'b1, 32'hA5A5_0F0F, 1'b0);
    do_req(1, 32'hA5A5_0F0F, 32'd32, MOD_SRL, a);
    wait_hs(2, "t1b_rsp");
    tick();
    push_exp(1'b0, 32'h0000_07F8, 1'b0);
    do_req(0, 32'h0000_00FF, 32'hFFFF_FFE3, MOD_SLL, a);
    wait_hs(3, "t1c_rsp");
    tick();

    // 2: both held after reset -> 0,1,0,1,0,1 at one op per two cycles.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      push_exp(1'b0, 32'hF800_0000 >> j | (j == 0 ? 32'h0 : 32'hF800_0000), 1'b0);
      push_exp(1'b1, 32'h0800_0000 >> j, 1'b0);
    end
    fork
      begin
        for (int j = 0; j < 3; j++) do_req(0, 32'h8000_0000, 32'(4 + j), MOD_SRA, a0s[j]);
      end
      begin
        for (int j = 0; j < 3; j++) do_req(1, 32'h8000_0000, 32'(4 + j), MOD_SRL, a1s[j]);
      end
    join
    chk("t2_ack_spacing", 32'(a1s[0] - a0s[0]), 32'd2);
    chk("t2_ack_alternate", 32'(a0s[1] - a1s[0]), 32'd2);
    wait_hs(9, "t2_rsp");
    tick();

    // 3: consumer stalls five cycles with requester 1 pending.
    bus.rsp_rdy = 1'b0;
    push_exp(1'b0, 32'h0000_0002, 1'b0);
    do_req(0, 32'h0000_0001, 32'd1, MOD_SLL, a0);
    push_exp(1'b1, 32'h0000_000F, 1'b0);
    stable = 1'b1;
    quiet  = 1'b1;
    fork
      do_req(1, 32'h0000_00F0, 32'd4, MOD_SRL, a1);
      begin
        @(negedge gclk);
        if (bus.req_ack != 2'b00) quiet = 1'b0;
        @(negedge gclk);
        snap_res = bus.rsp_res;
        snap_tag = bus.rsp_tag;
        snap_err = bus.rsp_err;
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge gclk);
          if (!bus.rsp_stb || bus.rsp_res !== snap_res || bus.rsp_tag !== snap_tag ||
              bus.rsp_err !== snap_err) stable = 1'b0;
          if (bus.req_ack != 2'b00) quiet = 1'b0;
        end
        tick();
        bus.rsp_rdy = 1'b1;
        @(negedge gclk);
        chk("t3_ack1_on_release", 32'(bus.req_ack), 32'h0000_0002);
      end
    join
    chk("t3_stall_stable", 32'(stable), 32'h1);
    chk("t3_stall_no_ack", 32'(quiet), 32'h1);
    chk("t3_stall_res", snap_res, 32'h0000_0002);
    wait_hs(11, "t3_rsp");
    chk("t3_latency", 32'(rise_cyc - a1), 32'd2);
    tick();

    // 4: illegal mode -> error, zero result, shifter mode field 00.
    push_exp(1'b1, 32'h0000_0000, 1'b1);
    do_req(1, 32'hFFFF_FFFF, 32'd5, MOD_ILL, a);
    @(negedge gclk);
    chk("t4_bsf_alt", 32'(bus.bsf_alt), 32'h0);
    wait_hs(12, "t4_rsp");
    tick();

    // 5: gena low for three cycles in EXEC.
    push_exp(1'b1, 32'hFFFF_FFFF, 1'b0);
    do_req(1, 32'h8000_0000, 32'd31, MOD_SRA, a);
    gena  = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge gclk);
      if (bus.rsp_stb) quiet = 1'b0;
    end
    chk("t5_frozen", 32'(quiet), 32'h1);
    tick();
    gena = 1'b1;
    wait_hs(13, "t5_rsp");
    chk("t5_latency", 32'(rise_cyc - a), 32'd5);
    tick();

    // 6: reset in EXEC discards the op; requester 0 wins the next tie.
    do_req(0, 32'h0000_0001, 32'd1, MOD_SLL, a);
    grst = 1'b1;
    @(negedge gclk);
    chk("t6_rst_rsp_tag", 32'(bus.rsp_tag), 32'h0);
    chk("t6_rst_rsp_res", bus.rsp_res, 32'h0);
    chk("t6_rst_bsf_opa", bus.bsf_opa, 32'h0);
    tick();
    grst  = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge gclk);
      if (bus.rsp_stb) quiet = 1'b0;
    end
    chk("t6_no_rsp", 32'(quiet), 32'h1);
    tick();
    push_exp(1'b0, 32'h0000_000F, 1'b0);
    push_exp(1'b1, 32'h8000_0000, 1'b0);
    fork
      do_req(0, 32'h0000_00F0, 32'd4, MOD_SRL, a0);
      do_req(1, 32'h0000_0001, 32'd31, MOD_SLL, a1);
    join
    chk("t6_req0_first", 32'(a1 - a0), 32'd2);
    wait_hs(15, "t6_rsp");
    tick();

    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
